// File: rtl/mem_initiator.sv
// -----------------------------------------------------------------------------
// mem_initiator
//
// Requester-side controller for a 4-line associative memory block. It takes one
// read or write request at a time from a client (valid/ready), drives the
// memory port for MEM_LAT cycles, samples dataOut/hit, and returns the result
// to the client over a second valid/ready handshake.
//
// Parameters
//   ADDR_W   request / memory address width
//   DATA_W   data path width
//   MEM_LAT  cycles the memory port is held before sampling (1..15)
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write/addr/wdata     request payload (1 = write)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_hit       read data (0 for writes and misses), hit flag
//   mem_address/dataIn/write outputs to the memory block
//   mem_dataOut, mem_hit     inputs from the memory block
//   busy                     controller is not idle
//
// Optional statistics (define MEM_INITIATOR_STATS_EN):
//   stat_clr   clear both counters (wins over an increment on the same edge)
//   stat_acc   completed transactions, saturating at 16'hFFFF
//   stat_miss  transactions that returned rsp_hit=0, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module mem_initiator #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_dataOut,
    input  logic              mem_hit,
`ifdef MEM_INITIATOR_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_acc,
    output logic [15:0]       stat_miss,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    // Counter load value: the counter reaches zero on the MEM_LAT-th ISSUE cycle.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_mem_lat
        $error("mem_initiator: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
    end

    state_t     state;
    state_t     state_next;
    logic [3:0] lat_cnt;
    logic       issue_done;

    // NOTE: reset is synchronous here, so it lives inside the clocked branch and
    // is not in the sensitivity list; state uses non-blocking assignment so all
    // flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        issue_done = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_cnt == 4'd0) begin
                    issue_done = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port, latency counter and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address <= '0;
            mem_dataIn  <= '0;
            mem_write   <= 1'b0;
            lat_cnt     <= 4'd0;
            rsp_rdata   <= '0;
            rsp_hit     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_address <= req_addr;
                        mem_dataIn  <= req_wdata;
                        mem_write   <= req_write;
                        lat_cnt     <= LAT_LOAD;
                    end else begin
                        // Address/data keep their last values; only the write
                        // strobe must never linger while idle.
                        mem_write <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        rsp_hit   <= mem_hit;
                        // Writes and misses return zero data.
                        rsp_rdata <= (!mem_write && mem_hit) ? mem_dataOut : '0;
                        mem_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_INITIATOR_STATS_EN
    always_ff @(posedge clock) begin
        if (reset || stat_clr) begin
            stat_acc  <= 16'd0;
            stat_miss <= 16'd0;
        end else if (issue_done) begin
            if (stat_acc != 16'hFFFF) begin
                stat_acc <= stat_acc + 16'd1;
            end
            // mem_hit is what rsp_hit captures on this same edge.
            if (!mem_hit && (stat_miss != 16'hFFFF)) begin
                stat_miss <= stat_miss + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_initiator
//
// Two controller instances share one clock: u_l1 (MEM_LAT=1) carries most of
// the scenarios, u_l4 (MEM_LAT=4) covers the longer latency and reset abort.
// Each instance talks to a small 4-line memory stub holding addresses 0..3
// (data 5,3,1,0). Expected responses come from an associative-array model of
// the memory contents. Inputs are driven and outputs sampled on the falling
// edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_mem_initiator;

    logic clock;
    int   n_checks = 0;
    int   n_errors = 0;

    // ---------------- MEM_LAT = 1 instance ----------------
    logic       l1_reset, l1_req_valid, l1_req_ready, l1_req_write;
    logic [7:0] l1_req_addr, l1_req_wdata;
    logic       l1_rsp_valid, l1_rsp_ready, l1_rsp_hit;
    logic [7:0] l1_rsp_rdata, l1_mem_address, l1_mem_din, l1_mem_dout;
    logic       l1_mem_write, l1_mem_hit, l1_busy;

    // ---------------- MEM_LAT = 4 instance ----------------
    logic       l4_reset, l4_req_valid, l4_req_ready, l4_req_write;
    logic [7:0] l4_req_addr, l4_req_wdata;
    logic       l4_rsp_valid, l4_rsp_ready, l4_rsp_hit;
    logic [7:0] l4_rsp_rdata, l4_mem_address, l4_mem_din, l4_mem_dout;
    logic       l4_mem_write, l4_mem_hit, l4_busy;

`ifdef MEM_INITIATOR_STATS_EN
    logic        l1_stat_clr, l4_stat_clr;
    logic [15:0] l1_stat_acc, l1_stat_miss, l4_stat_acc, l4_stat_miss;
`endif

    mem_initiator #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_l1 (
        .clock(clock), .reset(l1_reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready),
        .rsp_rdata(l1_rsp_rdata), .rsp_hit(l1_rsp_hit),
        .mem_address(l1_mem_address), .mem_dataIn(l1_mem_din), .mem_write(l1_mem_write),
        .mem_dataOut(l1_mem_dout), .mem_hit(l1_mem_hit),
`ifdef MEM_INITIATOR_STATS_EN
        .stat_clr(l1_stat_clr), .stat_acc(l1_stat_acc), .stat_miss(l1_stat_miss),
`endif
        .busy(l1_busy)
    );

    mem_initiator #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(4)) u_l4 (
        .clock(clock), .reset(l4_reset),
        .req_valid(l4_req_valid), .req_ready(l4_req_ready), .req_write(l4_req_write),
        .req_addr(l4_req_addr), .req_wdata(l4_req_wdata),
        .rsp_valid(l4_rsp_valid), .rsp_ready(l4_rsp_ready),
        .rsp_rdata(l4_rsp_rdata), .rsp_hit(l4_rsp_hit),
        .mem_address(l4_mem_address), .mem_dataIn(l4_mem_din), .mem_write(l4_mem_write),
        .mem_dataOut(l4_mem_dout), .mem_hit(l4_mem_hit),
`ifdef MEM_INITIATOR_STATS_EN
        .stat_clr(l4_stat_clr), .stat_acc(l4_stat_acc), .stat_miss(l4_stat_miss),
`endif
        .busy(l4_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory stubs: lines for addresses 0..3 ----------------
    logic [7:0] m1_data [4];
    logic [7:0] m4_data [4];
    logic       m1_load;

    always_comb begin
        l1_mem_hit  = (l1_mem_address < 8'd4);
        l1_mem_dout = l1_mem_hit ? m1_data[l1_mem_address[1:0]] : 8'h00;
        l4_mem_hit  = (l4_mem_address < 8'd4);
        l4_mem_dout = l4_mem_hit ? m4_data[l4_mem_address[1:0]] : 8'h00;
    end

    always @(posedge clock) begin
        if (m1_load) begin
            m1_data[0] <= 8'd5; m1_data[1] <= 8'd3; m1_data[2] <= 8'd1; m1_data[3] <= 8'd0;
        end else if (l1_mem_write && l1_mem_hit) begin
            m1_data[l1_mem_address[1:0]] <= l1_mem_din;
        end
    end

    always @(posedge clock) begin
        if (l4_reset) begin
            m4_data[0] <= 8'd5; m4_data[1] <= 8'd3; m4_data[2] <= 8'd1; m4_data[3] <= 8'd0;
        end else if (l4_mem_write && l4_mem_hit) begin
            m4_data[l4_mem_address[1:0]] <= l4_mem_din;
        end
    end

    // Monitors: write-strobe cycles on u_l1, response cycles on u_l4.
    int l1_wr_cycles = 0;
    int l4_rsp_seen  = 0;
    always @(posedge clock) begin
        if (l1_mem_write === 1'b1) l1_wr_cycles <= l1_wr_cycles + 1;
        if (l4_rsp_valid === 1'b1) l4_rsp_seen  <= l4_rsp_seen + 1;
    end

    // ---------------- reference model of u_l1's memory contents ----------------
    logic [7:0] ref_mem [logic [7:0]];

    function automatic void ref_reload();
        ref_mem.delete();
        ref_mem[8'd0] = 8'd5;
        ref_mem[8'd1] = 8'd3;
        ref_mem[8'd2] = 8'd1;
        ref_mem[8'd3] = 8'd0;
    endfunction

    // A present address hits; writes update it and return 0, reads return it.
    // Absent addresses miss, return 0 and change nothing.
    function automatic void ref_access(input logic wr, input logic [7:0] addr,
                                       input logic [7:0] wd,
                                       output logic hit, output logic [7:0] rdata);
        hit   = (ref_mem.exists(addr) != 0);
        rdata = 8'h00;
        if (hit) begin
            if (wr) ref_mem[addr] = wd;
            else    rdata = ref_mem[addr];
        end
    endfunction

    // ---------------- u_l1 transaction helpers ----------------
    task automatic reload_l1();
        m1_load = 1'b1;
        @(negedge clock);
        m1_load = 1'b0;
        ref_reload();
    endtask

    // Presents a request at a falling edge while idle; returns one cycle later.
    task automatic l1_issue(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        l1_req_valid = 1'b1;
        l1_req_write = wr;
        l1_req_addr  = addr;
        l1_req_wdata = wd;
        @(negedge clock);
        l1_req_valid = 1'b0;
    endtask

    // Waits for the response, compares it to the model, stalls rsp_ready for
    // 'stall' cycles checking stability, then completes the handshake.
    task automatic l1_finish(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                             input int stall, input string tag);
        logic       exp_hit;
        logic [7:0] exp_rdata;
        int         cycles = 0;
        ref_access(wr, addr, wd, exp_hit, exp_rdata);
        l1_rsp_ready = (stall == 0);
        while (l1_rsp_valid !== 1'b1 && cycles < 40) begin
            @(negedge clock);
            cycles++;
        end
        n_checks++;
        if (cycles !== 1) begin
            n_errors++;
            $display("FAIL %s latency: got %0d cycles, want 1", tag, cycles);
        end
        n_checks++;
        if ({l1_rsp_hit, l1_rsp_rdata} !== {exp_hit, exp_rdata}) begin
            n_errors++;
            $display("FAIL %s response: got hit=%b rdata=%h, want hit=%b rdata=%h",
                     tag, l1_rsp_hit, l1_rsp_rdata, exp_hit, exp_rdata);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            n_checks++;
            if ({l1_rsp_valid, l1_req_ready, l1_rsp_hit, l1_rsp_rdata, l1_mem_address} !==
                {1'b1, 1'b0, exp_hit, exp_rdata, addr}) begin
                n_errors++;
                $display("FAIL %s stall cycle %0d: got v=%b rdy=%b hit=%b rdata=%h addr=%h, want v=1 rdy=0 hit=%b rdata=%h addr=%h",
                         tag, i, l1_rsp_valid, l1_req_ready, l1_rsp_hit, l1_rsp_rdata,
                         l1_mem_address, exp_hit, exp_rdata, addr);
            end
        end
        l1_rsp_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({l1_rsp_valid, l1_req_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL %s handshake: got rsp_valid=%b req_ready=%b, want 0 1",
                     tag, l1_rsp_valid, l1_req_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++;
        if ({l1_req_ready, l1_rsp_valid, l1_rsp_hit, l1_mem_write, l1_busy} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_ctrl_l1: got %b, want 10000",
                     {l1_req_ready, l1_rsp_valid, l1_rsp_hit, l1_mem_write, l1_busy});
        end
        n_checks++;
        if ({l1_rsp_rdata, l1_mem_address, l1_mem_din} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_data_l1: got %h, want 000000",
                     {l1_rsp_rdata, l1_mem_address, l1_mem_din});
        end
        n_checks++;
        if ({l4_req_ready, l4_rsp_valid, l4_rsp_hit, l4_mem_write, l4_busy} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_ctrl_l4: got %b, want 10000",
                     {l4_req_ready, l4_rsp_valid, l4_rsp_hit, l4_mem_write, l4_busy});
        end
    endtask

    task automatic test_read_basic();
        logic       exp_hit;
        logic [7:0] exp_rdata;
        ref_access(1'b0, 8'd0, 8'd0, exp_hit, exp_rdata);
        l1_rsp_ready = 1'b1;
        l1_issue(1'b0, 8'd0, 8'd0);
        n_checks++;
        if ({l1_req_ready, l1_rsp_valid, l1_busy, l1_mem_write, l1_mem_address} !== {4'b0010, 8'd0}) begin
            n_errors++;
            $display("FAIL read0_issue: got rdy=%b v=%b busy=%b wr=%b addr=%h, want 0 0 1 0 00",
                     l1_req_ready, l1_rsp_valid, l1_busy, l1_mem_write, l1_mem_address);
        end
        @(negedge clock);
        n_checks++;
        if ({l1_req_ready, l1_rsp_valid, l1_rsp_hit, l1_rsp_rdata} !== {3'b011, 8'd5}) begin
            n_errors++;
            $display("FAIL read0_resp: got rdy=%b v=%b hit=%b rdata=%h, want 0 1 1 05",
                     l1_req_ready, l1_rsp_valid, l1_rsp_hit, l1_rsp_rdata);
        end
        @(negedge clock);
        n_checks++;
        if ({l1_req_ready, l1_rsp_valid, l1_busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL read0_idle: got rdy=%b v=%b busy=%b, want 1 0 0",
                     l1_req_ready, l1_rsp_valid, l1_busy);
        end
    endtask

    task automatic test_write_read();
        int w0;
        w0 = l1_wr_cycles;
        l1_issue(1'b1, 8'd2, 8'h0F);
        n_checks++;
        if ({l1_mem_write, l1_mem_address, l1_mem_din} !== {1'b1, 8'd2, 8'h0F}) begin
            n_errors++;
            $display("FAIL write2_port: got wr=%b addr=%h din=%h, want 1 02 0f",
                     l1_mem_write, l1_mem_address, l1_mem_din);
        end
        l1_finish(1'b1, 8'd2, 8'h0F, 0, "write2");
        n_checks++;
        if (l1_wr_cycles - w0 !== 1) begin
            n_errors++;
            $display("FAIL write2_strobe: got %0d write cycles, want 1", l1_wr_cycles - w0);
        end
        w0 = l1_wr_cycles;
        l1_issue(1'b0, 8'd2, 8'h00);
        l1_finish(1'b0, 8'd2, 8'h00, 0, "read2");
        n_checks++;
        if (l1_wr_cycles - w0 !== 0) begin
            n_errors++;
            $display("FAIL read2_strobe: got %0d write cycles, want 0", l1_wr_cycles - w0);
        end
    endtask

    task automatic test_miss();
        reload_l1();
        l1_issue(1'b0, 8'h07, 8'h00);
        l1_finish(1'b0, 8'h07, 8'h00, 0, "read_miss7");
        l1_issue(1'b1, 8'h07, 8'hAA);
        l1_finish(1'b1, 8'h07, 8'hAA, 0, "write_miss7");
        for (int a = 0; a < 4; a++) begin
            l1_issue(1'b0, 8'(a), 8'h00);
            l1_finish(1'b0, 8'(a), 8'h00, 0, "readback");
        end
    endtask

    task automatic test_stall();
        l1_issue(1'b0, 8'd1, 8'h00);
        // A second request is held throughout; it must be ignored until idle.
        l1_req_valid = 1'b1;
        l1_req_write = 1'b0;
        l1_req_addr  = 8'd2;
        l1_req_wdata = 8'h00;
        l1_finish(1'b0, 8'd1, 8'h00, 5, "stall_read1");
        n_checks++;
        if ({l1_busy, l1_mem_address} !== {1'b0, 8'd1}) begin
            n_errors++;
            $display("FAIL stall_not_yet: got busy=%b addr=%h, want 0 01", l1_busy, l1_mem_address);
        end
        @(negedge clock);
        l1_req_valid = 1'b0;
        n_checks++;
        if ({l1_busy, l1_mem_address} !== {1'b1, 8'd2}) begin
            n_errors++;
            $display("FAIL stall_accept: got busy=%b addr=%h, want 1 02", l1_busy, l1_mem_address);
        end
        l1_finish(1'b0, 8'd2, 8'h00, 0, "stall_next");
    endtask

    task automatic test_random();
        logic       wr;
        logic [7:0] addr, wd;
        reload_l1();
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 5));
            wd   = 8'($urandom);
            l1_issue(wr, addr, wd);
            l1_finish(wr, addr, wd, int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_abort_l4();
        int seen0;
        int cycles = 0;
        l4_rsp_ready = 1'b1;
        // Abort a write (addr 0) and then a read (addr 3) during the 2nd ISSUE cycle.
        for (int k = 0; k < 2; k++) begin
            seen0 = l4_rsp_seen;
            l4_req_valid = 1'b1;
            l4_req_write = (k == 0);
            l4_req_addr  = (k == 0) ? 8'd0 : 8'd3;
            l4_req_wdata = 8'h77;
            @(negedge clock);
            l4_req_valid = 1'b0;
            n_checks++;
            if ({l4_busy, l4_mem_write} !== {1'b1, (k == 0)}) begin
                n_errors++;
                $display("FAIL abort%0d_issue: got busy=%b wr=%b", k, l4_busy, l4_mem_write);
            end
            @(negedge clock);
            l4_reset = 1'b1;
            @(negedge clock);
            l4_reset = 1'b0;
            n_checks++;
            if ({l4_req_ready, l4_rsp_valid, l4_rsp_hit, l4_mem_write, l4_busy,
                 l4_rsp_rdata, l4_mem_address, l4_mem_din} !== {5'b10000, 24'h0}) begin
                n_errors++;
                $display("FAIL abort%0d_reset: got ctrl=%b data=%h, want 10000 000000", k,
                         {l4_req_ready, l4_rsp_valid, l4_rsp_hit, l4_mem_write, l4_busy},
                         {l4_rsp_rdata, l4_mem_address, l4_mem_din});
            end
            repeat (6) @(negedge clock);
            n_checks++;
            if (l4_rsp_seen - seen0 !== 0) begin
                n_errors++;
                $display("FAIL abort%0d_no_rsp: got %0d response cycles, want 0", k, l4_rsp_seen - seen0);
            end
        end
        l4_req_valid = 1'b1;
        l4_req_write = 1'b0;
        l4_req_addr  = 8'd3;
        @(negedge clock);
        l4_req_valid = 1'b0;
        while (l4_rsp_valid !== 1'b1 && cycles < 40) begin
            @(negedge clock);
            cycles++;
        end
        n_checks++;
        if (cycles !== 4) begin
            n_errors++;
            $display("FAIL l4_latency: got %0d cycles, want 4", cycles);
        end
        n_checks++;
        if ({l4_rsp_hit, l4_rsp_rdata} !== {1'b1, 8'h00}) begin
            n_errors++;
            $display("FAIL l4_read3: got hit=%b rdata=%h, want 1 00", l4_rsp_hit, l4_rsp_rdata);
        end
        @(negedge clock);
        n_checks++;
        if ({l4_rsp_valid, l4_req_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL l4_handshake: got v=%b rdy=%b, want 0 1", l4_rsp_valid, l4_req_ready);
        end
    endtask

`ifdef MEM_INITIATOR_STATS_EN
    task automatic test_stats();
        logic [7:0] addrs [5];
        addrs[0] = 8'd0; addrs[1] = 8'd1; addrs[2] = 8'd2; addrs[3] = 8'd7; addrs[4] = 8'd6;
        l1_stat_clr = 1'b1;
        @(negedge clock);
        l1_stat_clr = 1'b0;
        reload_l1();
        for (int i = 0; i < 5; i++) begin
            l1_issue(1'b0, addrs[i], 8'h00);
            l1_finish(1'b0, addrs[i], 8'h00, 0, "stats_txn");
        end
        n_checks++;
        if ({l1_stat_acc, l1_stat_miss} !== {16'd5, 16'd2}) begin
            n_errors++;
            $display("FAIL stats_count: got acc=%0d miss=%0d, want 5 2", l1_stat_acc, l1_stat_miss);
        end
        l1_stat_clr = 1'b1;
        @(negedge clock);
        l1_stat_clr = 1'b0;
        n_checks++;
        if ({l1_stat_acc, l1_stat_miss} !== 32'h0) begin
            n_errors++;
            $display("FAIL stats_clear: got acc=%0d miss=%0d, want 0 0", l1_stat_acc, l1_stat_miss);
        end
        force u_l1.stat_acc = 16'hFFFE;
        @(negedge clock);
        release u_l1.stat_acc;
        for (int i = 0; i < 3; i++) begin
            l1_issue(1'b0, 8'd0, 8'h00);
            l1_finish(1'b0, 8'd0, 8'h00, 0, "stats_sat");
        end
        n_checks++;
        if (l1_stat_acc !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL stats_saturate: got acc=%h, want ffff", l1_stat_acc);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        l1_reset = 1'b1; l4_reset = 1'b1; m1_load = 1'b1;
        l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = 8'h00; l1_req_wdata = 8'h00;
        l4_req_valid = 1'b0; l4_req_write = 1'b0; l4_req_addr = 8'h00; l4_req_wdata = 8'h00;
        l1_rsp_ready = 1'b0; l4_rsp_ready = 1'b0;
`ifdef MEM_INITIATOR_STATS_EN
        l1_stat_clr = 1'b0; l4_stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clock);
        l1_reset = 1'b0; l4_reset = 1'b0; m1_load = 1'b0;
        ref_reload();

        test_reset();
        test_read_basic();
        test_write_read();
        test_miss();
        test_stall();
        test_random();
        test_abort_l4();
`ifdef MEM_INITIATOR_STATS_EN
        test_stats();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
